// File: rtl/morse_char_buffer_pkg.sv
// Shared types for the morse character buffer: event kinds, packed symbol
// codes and the assembler state encoding.
package morse_pkg;

    // Event kinds as they arrive on in_kind
    typedef enum logic [1:0] {
        KIND_ENDSEQ = 2'b00,
        KIND_DOT    = 2'b01,
        KIND_DASH   = 2'b10,
        KIND_SPACE  = 2'b11
    } kind_e;

    // Two-bit symbol codes stored in each slot of a packed character
    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;

    // Character assembler states
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BUILD,
        ST_OVF
    } asm_state_e;

endpackage

// File: rtl/morse_char_buffer_if.sv
// Symbol-event input and character-queue output bundle of morse_char_buffer.
// The master side drives events and out_ready; the slave side is the buffer.
interface morse_char_buffer_if #(
    parameter int MAX_SYMS = 5,
    parameter int DEPTH    = 4
);
    localparam int LW  = $clog2(MAX_SYMS + 1);
    localparam int CW  = 2 * MAX_SYMS;
    localparam int LVW = $clog2(DEPTH + 1);

    logic           tick;
    logic           in_valid;
    logic [1:0]     in_kind;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  out_seq;
    logic [LW-1:0]  out_len;
    logic           out_err;
    logic           out_eow;
    logic [LVW-1:0] level;
    logic           full;
    logic           drop;

    modport master (
        output tick, in_valid, in_kind, out_ready,
        input  out_valid, out_seq, out_len, out_err, out_eow, level, full, drop
    );

    modport slave (
        input  tick, in_valid, in_kind, out_ready,
        output out_valid, out_seq, out_len, out_err, out_eow, level, full, drop
    );
endinterface

// File: rtl/morse_char_buffer_fifo.sv
// morse_char_fifo: synchronous FIFO of completed characters. DEPTH must be a
// power of two so the pointers wrap naturally. A push while full with no pop
// in the same cycle is discarded and reported by a one-cycle drop pulse.
module morse_char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       drop
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LVW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LVW-1:0]   level_q, level_d;
    logic             drop_q, drop_d;
    logic             do_pop, do_push;

    assign full    = (level_q == LVW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;
    assign drop    = drop_q;

    // Next pointer/occupancy values; clear wins over push and pop
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        drop_d   = 1'b0;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_push && !do_pop)      level_d = level_q + LVW'(1);
            else if (do_pop && !do_push) level_d = level_q - LVW'(1);
            drop_d = push & full & ~do_pop;
        end
    end

    // Pointer, occupancy and drop-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; level gates every read, so stale contents are never observed.
        if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/morse_char_buffer.sv
// morse_char_buffer: assembles dot/dash events into packed character codes
// and queues completed characters in a DEPTH-entry FIFO drained by
// valid/ready. Optional feature macro: MORSE_CHAR_BUFFER_EOW_EN (EndSeq
// marks end of word and can push a zero-length marker entry).
module morse_char_buffer
    import morse_pkg::*;
#(
    parameter int MAX_SYMS = 5,
    parameter int DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    morse_char_buffer_if.slave bus
);
    localparam int LW = $clog2(MAX_SYMS + 1);
    localparam int CW = 2 * MAX_SYMS;
`ifdef MORSE_CHAR_BUFFER_EOW_EN
    localparam int FW = CW + LW + 2;
`else
    localparam int FW = CW + LW + 1;
`endif

    asm_state_e     state_q, state_d;
    logic [CW-1:0]  code_q, code_d;
    logic [LW-1:0]  len_q, len_d;
    kind_e          kind;
    logic [1:0]     sym;
    logic           accept, is_sym;
    logic           push, push_err;
    logic [FW-1:0]  push_data, head_data;
    logic [CW-1:0]  head_seq;
    logic [LW-1:0]  head_len;
    logic           head_err, head_eow;
    logic           fifo_empty;
`ifdef MORSE_CHAR_BUFFER_EOW_EN
    logic           push_eow;
`endif

    assign kind   = kind_e'(bus.in_kind);
    assign accept = bus.tick & bus.in_valid & ~clear;
    assign is_sym = (kind == KIND_DOT) || (kind == KIND_DASH);
    assign sym    = (kind == KIND_DOT) ? SYM_DOT : SYM_DASH;

    // Assembler next state; a pushed entry always carries the current code/len
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        len_d    = len_q;
        push     = 1'b0;
        push_err = 1'b0;
`ifdef MORSE_CHAR_BUFFER_EOW_EN
        push_eow = 1'b0;
`endif
        if (clear) begin
            state_d = ST_EMPTY;
            code_d  = '0;
            len_d   = '0;
        end else if (accept) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (is_sym) begin
                        code_d      = {CW{1'b0}} | CW'(SYM_NONE);
                        code_d[1:0] = sym;
                        len_d       = LW'(1);
                        state_d     = ST_BUILD;
                    end
`ifdef MORSE_CHAR_BUFFER_EOW_EN
                    else if (kind == KIND_ENDSEQ) begin
                        push     = 1'b1;
                        push_eow = 1'b1;
                    end
`endif
                end
                ST_BUILD: begin
                    if (is_sym) begin
                        if (len_q == LW'(MAX_SYMS)) begin
                            state_d = ST_OVF;
                        end else begin
                            for (int i = 0; i < MAX_SYMS; i++) begin
                                if (len_q == LW'(i)) code_d[2*i +: 2] = sym;
                            end
                            len_d = len_q + LW'(1);
                        end
                    end else begin
                        push    = 1'b1;
                        state_d = ST_EMPTY;
                        code_d  = '0;
                        len_d   = '0;
`ifdef MORSE_CHAR_BUFFER_EOW_EN
                        push_eow = (kind == KIND_ENDSEQ);
`endif
                    end
                end
                ST_OVF: begin
                    if (!is_sym) begin
                        push     = 1'b1;
                        push_err = 1'b1;
                        state_d  = ST_EMPTY;
                        code_d   = '0;
                        len_d    = '0;
`ifdef MORSE_CHAR_BUFFER_EOW_EN
                        push_eow = (kind == KIND_ENDSEQ);
`endif
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Assembler state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            code_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
        end
    end

`ifdef MORSE_CHAR_BUFFER_EOW_EN
    assign push_data = {push_eow, push_err, len_q, code_q};
    assign {head_eow, head_err, head_len, head_seq} = head_data;
`else
    assign push_data = {push_err, len_q, code_q};
    assign {head_err, head_len, head_seq} = head_data;
    assign head_eow  = 1'b0;
`endif

    morse_char_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .wdata (push_data),
        .pop   (bus.out_ready),
        .rdata (head_data),
        .level (bus.level),
        .full  (bus.full),
        .empty (fifo_empty),
        .drop  (bus.drop)
    );

    // Head fields read as zero whenever the queue is empty
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_seq   = fifo_empty ? '0 : head_seq;
    assign bus.out_len   = fifo_empty ? '0 : head_len;
    assign bus.out_err   = ~fifo_empty & head_err;
    assign bus.out_eow   = ~fifo_empty & head_eow;
endmodule

// File: tb/tb_morse_char_buffer.sv
// Self-checking bench for morse_char_buffer: directed character scenarios
// with literal expectations, then randomized traffic against a queue model.
module tb_morse_char_buffer;
    localparam int MAX_SYMS = 5;
    localparam int DEPTH    = 4;
`ifdef MORSE_CHAR_BUFFER_EOW_EN
    localparam bit EOW_EN = 1'b1;
`else
    localparam bit EOW_EN = 1'b0;
`endif
    localparam logic [1:0] K_END = 2'b00, K_DOT = 2'b01, K_DASH = 2'b10, K_SPC = 2'b11;

    typedef struct {
        int seq;
        int len;
        bit err;
        bit eow;
    } entry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model: pending symbols, overflow flag, queued characters
    int     syms_m[$];
    bit     ovf_m  = 1'b0;
    entry_t fifo_m[$];
    bit     drop_m = 1'b0;

    morse_char_buffer_if #(.MAX_SYMS(MAX_SYMS), .DEPTH(DEPTH)) bus ();

    morse_char_buffer #(.MAX_SYMS(MAX_SYMS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        syms_m.delete();
        ovf_m = 1'b0;
        fifo_m.delete();
        drop_m = 1'b0;
    endtask

    // Model of one clock edge, computed from the character rules directly
    task automatic model_edge(input bit clr, input bit tk, input bit vl,
                              input logic [1:0] kd, input bit rdy);
        bit     push_c = 1'b0;
        bit     pop_c;
        entry_t e;
        e = '{0, 0, 1'b0, 1'b0};
        if (clr) begin
            model_reset();
            return;
        end
        pop_c = (fifo_m.size() > 0) && rdy;
        if (tk && vl) begin
            if (kd == K_DOT || kd == K_DASH) begin
                if (syms_m.size() < MAX_SYMS) syms_m.push_back(int'(kd));
                else ovf_m = 1'b1;
            end else if (syms_m.size() > 0) begin
                foreach (syms_m[i]) e.seq += syms_m[i] << (2 * i);
                e.len  = syms_m.size();
                e.err  = ovf_m;
                e.eow  = EOW_EN && (kd == K_END);
                push_c = 1'b1;
                syms_m.delete();
                ovf_m = 1'b0;
            end else if (EOW_EN && kd == K_END) begin
                e.eow  = 1'b1;
                push_c = 1'b1;
            end
        end
        drop_m = push_c && (fifo_m.size() == DEPTH) && !pop_c;
        if (pop_c) void'(fifo_m.pop_front());
        if (push_c && !drop_m) fifo_m.push_back(e);
    endtask

    // One cycle: drive inputs, advance the model at the edge, settle
    task automatic step(input bit clr, input bit tk, input bit vl,
                        input logic [1:0] kd, input bit rdy);
        clear         = clr;
        bus.tick      = tk;
        bus.in_valid  = vl;
        bus.in_kind   = kd;
        bus.out_ready = rdy;
        @(posedge clk);
        model_edge(clr, tk, vl, kd, rdy);
        #1;
    endtask

    task automatic send(input logic [1:0] kd, input bit rdy);
        step(1'b0, 1'b1, 1'b1, kd, rdy);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 1'b0, K_DOT, rdy);
    endtask

    // Literal expectation for the queue head, applied to DUT and model
    task automatic expect_head(input string tag, input int seq, input int len,
                               input bit err, input bit eow);
        check({tag, " valid"}, bus.out_valid, 1);
        check({tag, " seq"},   bus.out_seq, seq);
        check({tag, " len"},   bus.out_len, len);
        check({tag, " err"},   bus.out_err, err);
        check({tag, " eow"},   bus.out_eow, eow);
        check({tag, " model size"}, (fifo_m.size() > 0), 1);
        if (fifo_m.size() > 0) begin
            check({tag, " model seq"}, fifo_m[0].seq, seq);
            check({tag, " model len"}, fifo_m[0].len, len);
        end
    endtask

    // Compare process: every output against the model on each falling edge
    always @(negedge clk) begin
        entry_t h;
        h = '{0, 0, 1'b0, 1'b0};
        if (fifo_m.size() > 0) h = fifo_m[0];
        check("out_valid", bus.out_valid, (fifo_m.size() > 0));
        check("out_seq",   bus.out_seq,   h.seq);
        check("out_len",   bus.out_len,   h.len);
        check("out_err",   bus.out_err,   h.err);
        check("out_eow",   bus.out_eow,   h.eow);
        check("level",     bus.level,     fifo_m.size());
        check("full",      bus.full,      (fifo_m.size() == DEPTH));
        check("drop",      bus.drop,      drop_m);
    end

    initial begin
        bus.tick      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_kind   = K_DOT;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;

        // Reset state
        check("reset valid", bus.out_valid, 0);
        check("reset level", bus.level, 0);

        // dot dash dot space -> 0x019, len 3, valid the cycle after the space
        send(K_DOT, 0); send(K_DASH, 0); send(K_DOT, 0);
        check("ddd pre-space valid", bus.out_valid, 0);
        send(K_SPC, 0);
        expect_head("ddd", 'h019, 3, 0, 0);
        idle(1);
        check("ddd popped", bus.out_valid, 0);

        // six dashes then space -> overflow entry
        repeat (6) send(K_DASH, 0);
        send(K_SPC, 0);
        expect_head("ovf", 'h2AA, 5, 1, 0);
        idle(1);

        // fill the queue with four distinct characters
        send(K_DOT, 0);  send(K_SPC, 0);
        send(K_DASH, 0); send(K_SPC, 0);
        send(K_DOT, 0);  send(K_DOT, 0);  send(K_SPC, 0);
        send(K_DASH, 0); send(K_DASH, 0); send(K_SPC, 0);
        check("fill level", bus.level, 4);
        check("fill full", bus.full, 1);
        check("fill drop", bus.drop, 0);
        // fifth character is lost
        send(K_DASH, 0); send(K_DOT, 0); send(K_SPC, 0);
        check("drop pulse", bus.drop, 1);
        check("drop level", bus.level, 4);
        idle(0);
        check("drop cleared", bus.drop, 0);
        expect_head("after drop", 'h001, 1, 0, 0);
        // sixth completes while popping: no drop, level unchanged
        send(K_DOT, 0); send(K_DASH, 0); send(K_SPC, 1);
        check("push+pop drop", bus.drop, 0);
        check("push+pop level", bus.level, 4);
        expect_head("order1", 'h002, 1, 0, 0);
        idle(1); expect_head("order2", 'h005, 2, 0, 0);
        idle(1); expect_head("order3", 'h00A, 2, 0, 0);
        idle(1); expect_head("order4", 'h009, 2, 0, 0);
        idle(1);
        check("drained", bus.out_valid, 0);

        // dash, EndSeq, EndSeq
        send(K_DASH, 0); send(K_END, 0); send(K_END, 0);
        if (EOW_EN) begin
            check("eow level", bus.level, 2);
            expect_head("eow char", 'h002, 1, 0, 1);
            idle(1);
            expect_head("eow marker", 0, 0, 0, 1);
        end else begin
            check("noeow level", bus.level, 1);
            expect_head("noeow char", 'h002, 1, 0, 0);
        end
        idle(1);

        // clear with two entries queued and a partial character
        send(K_DOT, 0); send(K_SPC, 0); send(K_DASH, 0); send(K_SPC, 0);
        send(K_DASH, 0);
        step(1'b1, 1'b1, 1'b1, K_SPC, 1'b1);
        check("clear level", bus.level, 0);
        check("clear valid", bus.out_valid, 0);
        check("clear drop", bus.drop, 0);
        send(K_DOT, 0); send(K_SPC, 0);
        expect_head("post clear", 'h001, 1, 0, 0);
        idle(1);

        // asynchronous reset mid-character
        send(K_DASH, 0); send(K_SPC, 0); send(K_DOT, 0); send(K_DASH, 0);
        idle(0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async rst valid", bus.out_valid, 0);
        check("async rst level", bus.level, 0);
        check("async rst seq", bus.out_seq, 0);
        #1;
        rst_n = 1'b1;
        send(K_DOT, 0); send(K_SPC, 0);
        expect_head("post rst", 'h001, 1, 0, 0);
        idle(1);

        // randomized traffic with phases of consumer pressure
        for (int i = 0; i < 4000; i++) begin
            int  r;
            bit  clr;
            bit  rdy;
            logic [1:0] kd;
            r   = int'($urandom_range(0, 7));
            kd  = (r < 3) ? K_DOT : (r < 6) ? K_DASH : (r == 6) ? K_SPC : K_END;
            clr = ($urandom_range(0, 99) == 0);
            rdy = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                       : ($urandom_range(0, 3) != 0);
            step(clr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), kd, rdy);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
